// File: rtl/hit_stamp_fifo.sv
// rtl/hit_stamp_fifo.sv - timestamped hit capture FIFO with drop accounting
//
// Purpose:
//   Stamps each incoming hit pulse with a free-running timestamp and queues
//   the stamp in a small first-word-fall-through FIFO. Hits arriving while
//   the FIFO is full and not being drained are counted and flagged.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   hit       in   one-cycle match pulse
//   rd_en     in   consumer pop request
//   rd_data   out  timestamp at FIFO head, zero when empty
//   empty     out  FIFO holds no entries
//   full      out  FIFO holds DEPTH entries
//   count     out  number of stored entries
//   drop_cnt  out  saturating count of hits lost while full
//   ovf       out  sticky flag, set on first dropped hit

module hit_stamp_fifo #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4    // power of two, 2..16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hit,
  input  logic                   rd_en,
  output logic [TS_W-1:0]        rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt,
  output logic                   ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic do_wr;
  logic do_rd;
  logic do_drop;

  // Flags come from the registered count only, so no input reaches an output.
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full FIFO can still take a hit when the same edge pops the head.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = hit && (!full || rd_en);
  assign do_drop = hit && full && !rd_en;

  // Head is masked while empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);

      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);

      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (do_drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage is not reset; the write stores ts as it stood during the hit cycle.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wr_ptr] <= ts;
  end

endmodule

// File: tb/tb_hit_stamp_fifo.sv
// tb/tb_hit_stamp_fifo.sv - self-checking bench for hit_stamp_fifo
module tb_hit_stamp_fifo;

  localparam int TS_W  = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            hit;
  logic            rd_en;
  logic [TS_W-1:0] rd_data;
  logic            empty;
  logic            full;
  logic [2:0]      count;
  logic [7:0]      drop_cnt;
  logic            ovf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int exp_ts;
  int q[$];
  int exp_drop;
  bit exp_ovf;

  typedef struct {
    bit hit;
    bit rd;
    int cnt;
    bit emp;
    int data;
  } vec_t;

  vec_t tbl[10];

  hit_stamp_fifo #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .hit      (hit),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .drop_cnt (drop_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_ts   = 0;
    exp_drop = 0;
    exp_ovf  = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".rd_data"}, 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  // Called at a falling edge; drives one cycle of stimulus and checks after.
  task automatic step(input bit h, input bit r);
    bit was_full;
    bit pop;
    bit wr;
    hit   = h;
    rd_en = r;
    was_full = (q.size() == DEPTH);
    pop = r && (q.size() > 0);
    wr  = h && (!was_full || r);
    if (pop) chk("pop_data", 32'(rd_data), 32'(q[0]));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (wr) q.push_back(exp_ts);
    if (h && was_full && !r) begin
      exp_ovf = 1;
      if (exp_drop < 255) exp_drop++;
    end
    exp_ts = (exp_ts + 1) % (1 << TS_W);
    @(negedge clk);
    hit   = 0;
    rd_en = 0;
    check_model("step");
  endtask

  task automatic do_reset();
    rst   = 1;
    hit   = 0;
    rd_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    check_model("reset");
    rst = 0;
  endtask

  initial begin
    rst   = 1;
    hit   = 0;
    rd_en = 0;

    // Vectors applied right after reset release; index == ts during the cycle.
    tbl[0] = '{0, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 1, 0, 5};  // hit at ts=5
    tbl[6] = '{0, 1, 0, 1, 0};  // pop it
    tbl[7] = '{0, 1, 0, 1, 0};  // pop while empty ignored
    tbl[8] = '{1, 1, 1, 0, 8};  // hit+rd while empty: write only
    tbl[9] = '{0, 1, 0, 1, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].hit, tbl[i].rd);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].data));
    end

    // Fill with ts 2,3,4,7
    do_reset();
    step(0, 0); step(0, 0);
    step(1, 0); step(1, 0); step(1, 0);
    step(0, 0); step(0, 0);
    step(1, 0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.count", 32'(count), 32'd4);
    chk("fill.head", 32'(rd_data), 32'd2);

    // Drop at ts=10
    step(0, 0); step(0, 0);
    step(1, 0);
    chk("drop1.drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop1.ovf", 32'(ovf), 32'd1);
    chk("drop1.head", 32'(rd_data), 32'd2);

    // Simultaneous hit+pop while full at ts=20
    repeat (9) step(0, 0);
    step(1, 1);
    chk("hitpop.count", 32'(count), 32'd4);
    chk("hitpop.head", 32'(rd_data), 32'd3);

    // Saturate the drop counter
    repeat (300) step(1, 0);
    chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat.ovf", 32'(ovf), 32'd1);

    // Drain: expect 3,4,7,20
    step(0, 1);
    step(0, 1);
    step(0, 1);
    chk("drain.last", 32'(rd_data), 32'd20);
    step(0, 1);
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.ovf_kept", 32'(ovf), 32'd1);

    // Asynchronous reset with two entries stored and ovf set
    do_reset();
    repeat (4) step(1, 0);
    step(1, 0);
    step(0, 1);
    step(0, 1);
    chk("pre_arst.count", 32'(count), 32'd2);
    chk("pre_arst.ovf", 32'(ovf), 32'd1);
    #2 rst = 1;
    #1;
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.full", 32'(full), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.rd_data", 32'(rd_data), 32'd0);
    chk("arst.drop_cnt", 32'(drop_cnt), 32'd0);
    chk("arst.ovf", 32'(ovf), 32'd0);

    // Hits during reset are ignored
    hit = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hit.count", 32'(count), 32'd0);
    chk("rst_hit.empty", 32'(empty), 32'd1);
    model_clear();
    rst = 0;

    // First edge after release stores ts=0
    step(1, 0);
    chk("first.count", 32'(count), 32'd1);
    chk("first.rd_data", 32'(rd_data), 32'd0);
    step(1, 0);
    chk("second.head", 32'(rd_data), 32'd0);
    step(0, 1);
    chk("second.after_pop", 32'(rd_data), 32'd1);
    step(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_stamp_fifo.md
HIT_STAMP_FIFO -- requirements
Module: hit_stamp_fifo

Interface
REQ-001 Parameter TS_W, default 16: timestamp width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hit  input  1  one-cycle match pulse from the upstream sequence detector; sampled on rising clk edge.
REQ-006 rd_en  input  1  consumer pop request.
REQ-007 rd_data  output  TS_W  timestamp at the FIFO head; first-word-fall-through.
REQ-008 empty  output  1  FIFO holds zero entries.
REQ-009 full  output  1  FIFO holds DEPTH entries.
REQ-010 count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-011 drop_cnt  output  8  number of hits lost while full; saturates.
REQ-012 ovf  output  1  sticky flag, set on the first dropped hit.

Function
REQ-013 Free-running timestamp register ts (TS_W bits) increments by 1 every clock edge when rst is low, wrapping from 2^TS_W-1 to 0.
REQ-014 A hit sampled at an edge stores the pre-increment ts value, i.e. the value ts held during the hit cycle.
REQ-015 Write accepted when hit=1 and (not full, or full with rd_en=1); stored at write pointer; write pointer advances mod DEPTH.
REQ-016 Pop occurs when rd_en=1 and not empty; read pointer advances mod DEPTH.
REQ-017 rd_en while empty is ignored; no pointer, count or flag changes.
REQ-018 Write and pop at the same edge: both occur; count unchanged.
REQ-019 Write and rd_en at the same edge while empty: write occurs, pop is ignored; count becomes 1.
REQ-020 hit=1 while full and rd_en=0: hit dropped; drop_cnt increments by 1, saturating at 255; ovf set to 1.
REQ-021 ovf and drop_cnt are cleared only by rst.
REQ-022 count: +1 on write only, -1 on pop only, unchanged on both or neither; range 0..DEPTH.
REQ-023 empty = (count==0) and full = (count==DEPTH); both derived from registered state, with no combinational path from hit or rd_en.
REQ-024 rd_data = mem[read pointer] when not empty; all zeros when empty.
REQ-025 Data visible on rd_data the cycle after its write edge; latency from hit edge to rd_data valid: 1 clock.
REQ-026 No path from inputs to outputs is combinational; all outputs are functions of registered state only.
REQ-027 Timestamp wrap has no effect on FIFO operation; stored values are raw ts, with no wrap tagging.

Reset
REQ-028 rst=1 asynchronously forces ts=0, both pointers=0, count=0, drop_cnt=0, ovf=0, empty=1, full=0, rd_data=0.
REQ-029 Storage array contents need not be reset; never visible while empty.
REQ-030 rst asserted mid-operation discards all stored entries immediately; hits during rst are ignored.
REQ-031 First edge after rst deasserts: ts goes 0->1; a hit at that edge stores 0.

Verification
REQ-032 Release rst, pulse hit in the cycle where ts=5 -> next cycle empty=0, count=1, rd_data=5; rd_en one cycle -> empty=1, rd_data=0.
REQ-033 Hits at ts=2,3,4,7 (DEPTH=4) -> full=1, count=4; pop four times -> rd_data sequence 2,3,4,7, then empty=1.
REQ-034 FIFO full, hit at ts=10 with rd_en=0 -> drop_cnt=1, ovf=1, contents unchanged; 300 further dropped hits -> drop_cnt=255.
REQ-035 FIFO full, hit and rd_en at the same edge with ts=20 -> count stays 4, head advances, 20 becomes the last entry popped.
REQ-036 Empty, hit and rd_en at the same edge with ts=8 -> count=1, rd_data=8.
REQ-037 Two entries stored, ovf=1, assert rst asynchronously mid-cycle -> outputs hit reset values before the next clk edge.
